// File: rtl/fwd_hazard_unit.sv
// Registered operand-forwarding selects and RAW hazard stall for the EXE stage.
// Latency: sel registered 1 clk after ID; stall is combinational; freeze holds all state.
module fwd_hazard_unit #(
    parameter int NUM_SRC    = 2,
    parameter int REG_W      = 4,
    parameter int DEPTH      = 2,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_fwd_en,
    input  logic                       i_freeze,
    input  logic                       i_flush,
    input  logic                       i_id_valid,
    input  logic [NUM_SRC*REG_W-1:0]   i_id_src,
    input  logic [NUM_SRC-1:0]         i_id_src_used,
    input  logic [REG_W-1:0]           i_id_dst,
    input  logic                       i_id_wb_en,
    input  logic                       i_id_is_load,
    output logic [NUM_SRC*SEL_W-1:0]   o_sel,
    output logic                       o_stall,
    output logic [CNT_W-1:0]           o_stall_cnt
);

    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic [REG_W-1:0] dst;
        logic             is_load;
    } ent_t;

    ent_t                     r_exe;
    ent_t                     r_stg [1:DEPTH];
    logic [NUM_SRC*SEL_W-1:0] r_sel;
    logic [CNT_W-1:0]         r_cnt;

    ent_t                     w_pos [1:DEPTH];
    ent_t                     w_id_ent;
    logic [SEL_W-1:0]         w_near [NUM_SRC];
    logic                     w_near_ld [NUM_SRC];
    logic [NUM_SRC*SEL_W-1:0] w_sel_nxt;
    logic                     w_hazard;
    logic                     w_stall;
    logic                     w_accept;

    // Producers as seen from the consumer's EXE cycle: position p = distance after advance.
    always_comb begin
        w_pos[1] = r_exe;
        for (int p = 2; p <= DEPTH; p++) begin
            w_pos[p] = r_stg[p-1];
        end
    end

    always_comb begin
        w_hazard  = 1'b0;
        w_sel_nxt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_near[i]    = '0;
            w_near_ld[i] = 1'b0;
            // Scan oldest to youngest so the nearest producer overwrites older ones.
            for (int p = DEPTH; p >= 1; p--) begin
                if (i_id_src_used[i] && w_pos[p].valid && w_pos[p].wb_en &&
                    (w_pos[p].dst == i_id_src[i*REG_W +: REG_W])) begin
                    w_near[i]    = SEL_W'(p);
                    w_near_ld[i] = w_pos[p].is_load;
                end
            end
            if (i_fwd_en) begin
                w_sel_nxt[i*SEL_W +: SEL_W] = w_near[i];
                if ((w_near[i] != '0) && w_near_ld[i] && (int'(w_near[i]) < LOAD_READY)) begin
                    w_hazard = 1'b1;
                end
            end else if (w_near[i] != '0) begin
                w_hazard = 1'b1;
            end
        end
    end

    always_comb begin
        w_id_ent         = '0;
        w_id_ent.valid   = 1'b1;
        w_id_ent.wb_en   = i_id_wb_en;
        w_id_ent.dst     = i_id_dst;
        w_id_ent.is_load = i_id_is_load;
    end

    assign w_stall  = i_id_valid & w_hazard & ~i_freeze & ~i_flush;
    assign w_accept = i_id_valid & ~w_stall & ~i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exe <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_stg[k] <= '0;
            end
            r_sel <= '0;
            r_cnt <= '0;
        end else if (!i_freeze) begin
            r_stg[1] <= r_exe;
            for (int k = 2; k <= DEPTH; k++) begin
                r_stg[k] <= r_stg[k-1];
            end
            r_exe <= w_accept ? w_id_ent : '0;
            r_sel <= w_accept ? w_sel_nxt : '0;
            if (w_stall && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_sel       = r_sel;
    assign o_stall     = w_stall;
    assign o_stall_cnt = r_cnt;

endmodule
